// File: rtl/neuron_spike_out_fifo_pkg.sv
// Shared definitions for the spike output FIFO: register map offsets, STATUS
// field positions, CONTROL bit positions and the register decode helper.
package neuron_spike_out_fifo_pkg;

   typedef enum logic [1:0] {
      REG_DATA,
      REG_STATUS,
      REG_CONTROL,
      REG_NONE
   } reg_kind_e;

   // Register offsets are relative to the end of the DATA window (NUM_WORDS).
   localparam int STATUS_OFS_AFTER_DATA  = 0;
   localparam int CONTROL_OFS_AFTER_DATA = 1;

   localparam int ST_COUNT_LSB = 0;
   localparam int ST_EMPTY_BIT = 5;
   localparam int ST_FULL_BIT  = 6;
   localparam int ST_OVF_BIT   = 7;
   localparam int ST_WRIDX_LSB = 8;

   localparam int CTRL_POP_BIT     = 0;
   localparam int CTRL_FLUSH_BIT   = 1;
   localparam int CTRL_CLR_OVF_BIT = 2;

   function automatic reg_kind_e decode_offset(input logic [31:0] offset, input int num_words);
      if (offset < 32'(num_words))
         return REG_DATA;
      else if (offset == 32'(num_words + STATUS_OFS_AFTER_DATA))
         return REG_STATUS;
      else if (offset == 32'(num_words + CONTROL_OFS_AFTER_DATA))
         return REG_CONTROL;
      else
         return REG_NONE;
   endfunction

endpackage

// File: rtl/neuron_spike_out_fifo_if.sv
// Wishbone slave bus bundle for the spike output FIFO register window.
interface neuron_spike_out_fifo_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/neuron_spike_frame_mem.sv
// Frame storage: DEPTH*NUM_WORDS words of 32 bits, one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
module neuron_spike_frame_mem #(
   parameter int NUM_WORDS = 8,
   parameter int DEPTH     = 4,
   localparam int AW       = $clog2(DEPTH * NUM_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH*NUM_WORDS];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/neuron_spike_out_fifo.sv
// Spike frame FIFO: the neuron core streams NUM_WORDS-word frames in, a
// Wishbone master reads the head frame, STATUS, and pops/flushes via CONTROL.
module neuron_spike_out_fifo
   import neuron_spike_out_fifo_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_2000,
   parameter int          NUM_WORDS = 8,
   parameter int          DEPTH     = 4
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   neuron_spike_out_fifo_if.slave  wb,
   input  logic [31:0]             external_spike_data_i,
   input  logic                    external_write_en_i,
   output logic                    frame_avail_o,
   output logic                    full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = 5;
   localparam int IDX_W = 7;
   localparam int AW    = $clog2(DEPTH * NUM_WORDS);

   logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [IDX_W-1:0] wr_idx_reg;
   logic             drop_reg, overflow_reg;
   logic             ack_reg, frame_avail_reg, full_reg;
   logic [31:0]      dat_reg;

   logic [31:0] byte_ofs, offset, status_word, rd_value, mem_rdata;
   reg_kind_e   kind;
   logic        req, ctrl_wr, pop_cmd, flush_cmd, clr_ovf_cmd, do_pop;
   logic        fifo_empty, fifo_full, word0, last_word, drop_now, mem_we, commit;
   logic [AW-1:0] waddr, raddr;

   assign byte_ofs = wb.wbs_adr_i - BASE_ADDR;
   assign offset   = {2'b00, byte_ofs[31:2]};
   assign kind     = decode_offset(offset, NUM_WORDS);

   // The !ack_reg term makes a held request complete every other cycle only.
   assign req         = wb.wbs_cyc_i && wb.wbs_stb_i && (kind != REG_NONE) && !ack_reg;
   assign ctrl_wr     = req && wb.wbs_we_i && (kind == REG_CONTROL) && wb.wbs_sel_i[0];
   assign pop_cmd     = ctrl_wr && wb.wbs_dat_i[CTRL_POP_BIT];
   assign flush_cmd   = ctrl_wr && wb.wbs_dat_i[CTRL_FLUSH_BIT];
   assign clr_ovf_cmd = ctrl_wr && wb.wbs_dat_i[CTRL_CLR_OVF_BIT];

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == CNT_W'(DEPTH));
   assign do_pop     = pop_cmd && !fifo_empty;

   // Drop decision is taken on word 0 and held for the rest of that frame.
   assign word0     = (wr_idx_reg == '0);
   assign last_word = (wr_idx_reg == IDX_W'(NUM_WORDS - 1));
   assign drop_now  = word0 ? fifo_full : drop_reg;
   assign mem_we    = external_write_en_i && !drop_now && !flush_cmd;
   assign commit    = external_write_en_i && last_word && !drop_now;

   assign waddr = AW'(wr_ptr_reg) * AW'(NUM_WORDS) + AW'(wr_idx_reg);
   assign raddr = AW'(rd_ptr_reg) * AW'(NUM_WORDS) + AW'(offset);

   neuron_spike_frame_mem #(
      .NUM_WORDS (NUM_WORDS),
      .DEPTH     (DEPTH)
   ) u_frame_mem (
      .clk   (wb_clk_i),
      .we    (mem_we),
      .waddr (waddr),
      .wdata (external_spike_data_i),
      .raddr (raddr),
      .rdata (mem_rdata)
   );

   always_comb begin
      count_next = count_reg;
      case ({commit, do_pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
      if (flush_cmd)
         count_next = '0;
   end

   always_comb begin
      status_word                           = '0;
      status_word[ST_COUNT_LSB +: CNT_W]    = count_reg;
      status_word[ST_EMPTY_BIT]             = fifo_empty;
      status_word[ST_FULL_BIT]              = fifo_full;
      status_word[ST_OVF_BIT]               = overflow_reg;
      status_word[ST_WRIDX_LSB +: 8]        = {1'b0, wr_idx_reg};
   end

   always_comb begin
      rd_value = '0;
      if (!wb.wbs_we_i) begin
         case (kind)
            REG_DATA:   rd_value = fifo_empty ? 32'h0 : mem_rdata;
            REG_STATUS: rd_value = status_word;
            default:    rd_value = '0;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
         count_reg       <= '0;
         wr_idx_reg      <= '0;
         drop_reg        <= 1'b0;
         overflow_reg    <= 1'b0;
         ack_reg         <= 1'b0;
         dat_reg         <= '0;
         frame_avail_reg <= 1'b0;
         full_reg        <= 1'b0;
      end else begin
         ack_reg <= req;
         if (req)
            dat_reg <= rd_value;

         count_reg       <= count_next;
         frame_avail_reg <= (count_next != '0);
         full_reg        <= (count_next == CNT_W'(DEPTH));

         if (flush_cmd) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            wr_idx_reg <= '0;
            drop_reg   <= 1'b0;
         end else begin
            if (do_pop)
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (commit)
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (external_write_en_i) begin
               wr_idx_reg <= last_word ? '0 : wr_idx_reg + 1'b1;
               if (word0)
                  drop_reg <= fifo_full;
            end
         end

         if (clr_ovf_cmd)
            overflow_reg <= 1'b0;
         if (external_write_en_i && word0 && fifo_full)
            overflow_reg <= 1'b1;
      end
   end

   assign wb.wbs_ack_o  = ack_reg;
   assign wb.wbs_dat_o  = dat_reg;
   assign frame_avail_o = frame_avail_reg;
   assign full_o        = full_reg;

endmodule
